dma_priority_arbiter: RTL



---
 rtl/dma_priority_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dma_priority_arbiter.sv
// DMA request/priority arbiter.
// Synchronises the DREQ lines and merges them with the software request bits.
// Masking and the command-register controls are applied before arbitration.
// Raises HRQ, waits for HLDA, then picks one channel by fixed or rotating
// priority. The winner is held on chanSel and DACK until the service
// completes or the CPU withdraws HLDA.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_CH-1:0]         DREQ,
    input  logic                      HLDA,
    input  logic [NUM_CH-1:0]         maskReg,
    input  logic [NUM_CH-1:0]         requestReg,
    input  logic [7:0]                commandReg,
    input  logic                      serviceDone,
    output logic                      HRQ,
    output logic [NUM_CH-1:0]         DACK,
    output logic [$clog2(NUM_CH)-1:0] chanSel,
    output logic                      chanValid,
    output logic                      grant,
    output logic [NUM_CH-1:0]         swReqClr
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SVC     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Command register fields
    logic cmd_disable;
    logic cmd_rotate;
    logic cmd_dreq_low;
    logic cmd_dack_high;

    assign cmd_disable   = commandReg[2];
    assign cmd_rotate    = commandReg[4];
    assign cmd_dreq_low  = commandReg[6];
    assign cmd_dack_high = commandReg[7];

    // Remaining command bits belong to the timing block, not to arbitration.
    logic unused_cmd;
    assign unused_cmd = ^{commandReg[5], commandReg[3], commandReg[1:0]};

    // Registered state
    state_t            state_q, state_d;
    logic              hrq_q, hrq_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [CH_W-1:0]   chan_sel_q, chan_sel_d;
    logic              chan_valid_q, chan_valid_d;
    logic              grant_q, grant_d;
    logic [NUM_CH-1:0] sw_req_clr_q, sw_req_clr_d;
    logic [CH_W-1:0]   top_pri_q, top_pri_d;
    logic [NUM_CH-1:0] dreq_sync_q, dreq_sync_d;

    // Request qualification
    logic [NUM_CH-1:0] pending;
    logic              any_req;
    logic [CH_W-1:0]   prio_base;
    logic [CH_W-1:0]   winner;

    // Scan from the highest-priority channel downwards, wrapping modulo
    // NUM_CH (NUM_CH is a power of two, so the CH_W-bit add wraps for free).
    function automatic logic [CH_W-1:0] pick_winner(
        input logic [NUM_CH-1:0] req,
        input logic [CH_W-1:0]   top
    );
        logic [CH_W-1:0] win;
        logic [CH_W-1:0] idx;
        logic            found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = top + CH_W'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Normalise DREQ polarity ahead of the synchroniser so everything
    // downstream sees active-high requests.
    always_comb begin
        dreq_sync_d = DREQ ^ {NUM_CH{cmd_dreq_low}};
    end

    // Merge hardware and software requests; software requests bypass the mask.
    always_comb begin
        pending   = (dreq_sync_q & ~maskReg) | requestReg;
        any_req   = (|pending) & ~cmd_disable;
        prio_base = cmd_rotate ? top_pri_q : '0;
        winner    = pick_winner(pending, prio_base);
    end

    // Next-state and output logic for the hold/grant handshake.
    always_comb begin
        state_d      = state_q;
        hrq_d        = hrq_q;
        ack_d        = ack_q;
        chan_sel_d   = chan_sel_q;
        chan_valid_d = chan_valid_q;
        grant_d      = 1'b0;
        sw_req_clr_d = '0;
        top_pri_d    = top_pri_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    hrq_d   = 1'b1;
                    state_d = REQ;
                end
            end

            REQ: begin
                hrq_d = 1'b1;
                // Arbitrate only on the HLDA cycle; before that, pending may
                // come and go freely.
                if (HLDA) begin
                    if (any_req) begin
                        chan_sel_d         = winner;
                        ack_d              = '0;
                        ack_d[winner]      = 1'b1;
                        chan_valid_d       = 1'b1;
                        grant_d            = 1'b1;
                        state_d            = SVC;
                    end else begin
                        hrq_d   = 1'b0;
                        state_d = RELEASE;
                    end
                end
            end

            SVC: begin
                // Selection is frozen; competing requests wait for the next round.
                if (serviceDone) begin
                    hrq_d                    = 1'b0;
                    ack_d                    = '0;
                    chan_valid_d             = 1'b0;
                    sw_req_clr_d[chan_sel_q] = 1'b1;
                    if (cmd_rotate) begin
                        top_pri_d = chan_sel_q + CH_W'(1);
                    end
                    state_d = RELEASE;
                end else if (!HLDA) begin
                    // CPU took the bus back: abandon without crediting the channel.
                    hrq_d        = 1'b0;
                    ack_d        = '0;
                    chan_valid_d = 1'b0;
                    state_d      = RELEASE;
                end
            end

            RELEASE: begin
                // Guarantees HRQ is low for at least one cycle between services.
                hrq_d = 1'b0;
                if (!HLDA) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Leaving rotating mode restores the fixed 0..3 ordering.
        if (!cmd_rotate) begin
            top_pri_d = '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            hrq_q        <= 1'b0;
            ack_q        <= '0;
            chan_sel_q   <= '0;
            chan_valid_q <= 1'b0;
            grant_q      <= 1'b0;
            sw_req_clr_q <= '0;
            top_pri_q    <= '0;
            dreq_sync_q  <= '0;
        end else begin
            state_q      <= state_d;
            hrq_q        <= hrq_d;
            ack_q        <= ack_d;
            chan_sel_q   <= chan_sel_d;
            chan_valid_q <= chan_valid_d;
            grant_q      <= grant_d;
            sw_req_clr_q <= sw_req_clr_d;
            top_pri_q    <= top_pri_d;
            dreq_sync_q  <= dreq_sync_d;
        end
    end

    // Output mapping; DACK polarity follows the command register live.
    assign HRQ       = hrq_q;
    assign DACK      = ack_q ^ {NUM_CH{~cmd_dack_high}};
    assign chanSel   = chan_sel_q;
    assign chanValid = chan_valid_q;
    assign grant     = grant_q;
    assign swReqClr  = sw_req_clr_q;

endmodule
